// File: rtl/rom_arbiter_if.sv
// Bundle of the two requester channels and the ROM read port around rom_arbiter.
interface rom_arbiter_if #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 32
);
    logic               if_req;
    logic [ADDR_W-1:0]  if_addr;
    logic               if_gnt;
    logic               if_rvalid;
    logic [INSTR_W-1:0] if_rdata;
    logic               ld_req;
    logic [ADDR_W-1:0]  ld_addr;
    logic               ld_gnt;
    logic               ld_rvalid;
    logic [INSTR_W-1:0] ld_rdata;
    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_q;

    // Arbiter side
    modport slave (
        input  if_req, if_addr, ld_req, ld_addr, rom_q,
        output if_gnt, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata, rom_addr
    );

    // Requester / ROM side
    modport master (
        output if_req, if_addr, ld_req, ld_addr, rom_q,
        input  if_gnt, if_rvalid, if_rdata, ld_gnt, ld_rvalid, ld_rdata, rom_addr
    );
endinterface

// File: rtl/rom_arbiter.sv
// Two-way arbiter for the instruction ROM read port: fetch wins by default,
// the load port is forced through after MAX_WAIT consecutive lost cycles.
// Read data comes back registered, one cycle after the grant.
module rom_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int INSTR_W  = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    rom_arbiter_if.slave bus
);
    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_LD} owner_e;

    owner_e             owner, owner_nxt;
    logic [3:0]         wait_cnt, wait_cnt_nxt;
    logic [ADDR_W-1:0]  last_addr;
    logic [INSTR_W-1:0] if_rdata_q, ld_rdata_q;
    logic               if_gnt, ld_gnt, ld_force;

    // Grant decision, address mux and next owner/wait count
    always_comb begin
        ld_force     = (wait_cnt == WAIT_MAX);
        // No grants while reset is held so the ROM address stays parked at 0.
        ld_gnt       = rst_n && bus.ld_req && (!bus.if_req || ld_force);
        if_gnt       = rst_n && bus.if_req && !ld_gnt;
        bus.rom_addr = last_addr;
        owner_nxt    = OWN_NONE;
        if (ld_gnt) begin
            bus.rom_addr = bus.ld_addr;
            owner_nxt    = OWN_LD;
        end else if (if_gnt) begin
            bus.rom_addr = bus.if_addr;
            owner_nxt    = OWN_IF;
        end
        wait_cnt_nxt = '0;
        if (bus.ld_req && !ld_gnt)
            wait_cnt_nxt = ld_force ? wait_cnt : wait_cnt + 4'd1;
    end

    // Owner register: which requester gets the data returned next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) owner <= OWN_NONE;
        else        owner <= owner_nxt;
    end

    // Starvation counter, parked ROM address and per-requester data capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt   <= '0;
            last_addr  <= '0;
            if_rdata_q <= '0;
            ld_rdata_q <= '0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
            if (owner_nxt != OWN_NONE) last_addr  <= bus.rom_addr;
            if (owner_nxt == OWN_IF)   if_rdata_q <= bus.rom_q;
            if (owner_nxt == OWN_LD)   ld_rdata_q <= bus.rom_q;
        end
    end

    // rvalid follows the owner register, so async reset kills a pending pulse at once
    always_comb begin
        bus.if_gnt    = if_gnt;
        bus.ld_gnt    = ld_gnt;
        bus.if_rvalid = (owner == OWN_IF);
        bus.ld_rvalid = (owner == OWN_LD);
        bus.if_rdata  = if_rdata_q;
        bus.ld_rdata  = ld_rdata_q;
    end
endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: directed scenarios then randomized traffic,
// all checked against a cycle-level reference model of the arbitration rules.
module tb_rom_arbiter;
    localparam int ADDR_W   = 5;
    localparam int INSTR_W  = 32;
    localparam int MAX_WAIT = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rom_arbiter_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

    rom_arbiter #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [INSTR_W-1:0] rom [2**ADDR_W];
    assign bus.rom_q = rom[bus.rom_addr];

    int n_comp = 0;
    int n_fail = 0;

    // Reference model state
    int                 m_wait;
    int                 m_own;     // 0 none, 1 fetch, 2 load (data due this cycle)
    logic [INSTR_W-1:0] m_if_data, m_ld_data;
    logic [ADDR_W-1:0]  m_last_addr;
    logic               e_if_gnt, e_ld_gnt;

    task automatic chk(input string tag, input logic [INSTR_W-1:0] got, input logic [INSTR_W-1:0] exp);
        n_comp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_wait = 0; m_own = 0; m_if_data = '0; m_ld_data = '0; m_last_addr = '0;
    endtask

    // One clock cycle: drive at negedge, check just before posedge, update model after it.
    task automatic cycle(input logic ir, input logic [ADDR_W-1:0] ia,
                         input logic lr, input logic [ADDR_W-1:0] la);
        logic [ADDR_W-1:0] e_addr;
        bus.if_req = ir; bus.if_addr = ia; bus.ld_req = lr; bus.ld_addr = la;
        #4;
        e_ld_gnt = lr && (!ir || m_wait >= MAX_WAIT);
        e_if_gnt = ir && !e_ld_gnt;
        e_addr   = e_ld_gnt ? la : (e_if_gnt ? ia : m_last_addr);
        chk("if_gnt",    32'(bus.if_gnt),    32'(e_if_gnt));
        chk("ld_gnt",    32'(bus.ld_gnt),    32'(e_ld_gnt));
        chk("rom_addr",  32'(bus.rom_addr),  32'(e_addr));
        chk("if_rvalid", 32'(bus.if_rvalid), 32'(m_own == 1));
        chk("ld_rvalid", 32'(bus.ld_rvalid), 32'(m_own == 2));
        chk("if_rdata",  bus.if_rdata, m_if_data);
        chk("ld_rdata",  bus.ld_rdata, m_ld_data);
        @(posedge clk);
        m_own = e_ld_gnt ? 2 : (e_if_gnt ? 1 : 0);
        if (e_if_gnt) m_if_data = rom[e_addr];
        if (e_ld_gnt) m_ld_data = rom[e_addr];
        if (e_if_gnt || e_ld_gnt) m_last_addr = e_addr;
        m_wait = (lr && !e_ld_gnt) ? ((m_wait + 1 > MAX_WAIT) ? MAX_WAIT : m_wait + 1) : 0;
        @(negedge clk);
    endtask

    logic              r_ir, r_lr;
    logic [ADDR_W-1:0] r_ia, r_la;

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) rom[i] = $urandom;
        rom[3] = 32'h0050_0093;

        // Reset held with both requesters active
        rst_n = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = 5'd12; bus.ld_req = 1'b1; bus.ld_addr = 5'd20;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        chk("rst_ld_rvalid", 32'(bus.ld_rvalid), 32'd0);
        chk("rst_if_rdata",  bus.if_rdata, 32'd0);
        chk("rst_ld_rdata",  bus.ld_rdata, 32'd0);
        chk("rst_rom_addr",  32'(bus.rom_addr), 32'd0);
        rst_n = 1'b1;

        // First fetch after reset
        cycle(1'b1, 5'd3, 1'b0, 5'd0);
        cycle(1'b0, 5'd0, 1'b0, 5'd0);
        chk("first_fetch_data", bus.if_rdata, 32'h0050_0093);

        // Fetch stream 0..3 back to back
        for (int a = 0; a < 4; a++) cycle(1'b1, 5'(a), 1'b0, 5'd0);
        cycle(1'b0, 5'd0, 1'b0, 5'd0);

        // Contention: load forced in on the fifth cycle
        for (int c = 0; c < 7; c++) cycle(1'b1, 5'(10 + c), 1'b1, 5'd7);
        cycle(1'b0, 5'd0, 1'b0, 5'd0);

        // Load alone at the top address
        cycle(1'b0, 5'd0, 1'b1, 5'd31);
        cycle(1'b0, 5'd0, 1'b0, 5'd0);
        chk("load31_data", bus.ld_rdata, rom[31]);

        // Idle hold after a grant to 9
        cycle(1'b1, 5'd9, 1'b0, 5'd0);
        for (int c = 0; c < 3; c++) cycle(1'b0, 5'($urandom), 1'b0, 5'($urandom));
        chk("idle_hold_addr", 32'(bus.rom_addr), 32'd9);

        // Async reset between the grant edge and the next edge
        cycle(1'b0, 5'd0, 1'b1, 5'd5);
        bus.ld_req = 1'b0;
        chk("pre_rst_ld_rvalid", 32'(bus.ld_rvalid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_ld_rvalid", 32'(bus.ld_rvalid), 32'd0);
        chk("midrst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
        chk("midrst_ld_rdata",  bus.ld_rdata, 32'd0);
        model_reset();
        #2 rst_n = 1'b1;
        @(negedge clk);
        cycle(1'b0, 5'd0, 1'b0, 5'd0);
        cycle(1'b0, 5'd0, 1'b0, 5'd0);

        // Randomized traffic obeying hold-until-grant, with occasional drops
        r_ir = 1'b0; r_lr = 1'b0; r_ia = '0; r_la = '0;
        for (int c = 0; c < 400; c++) begin
            if (!r_ir || e_if_gnt || $urandom_range(9) == 0) begin
                r_ir = ($urandom_range(3) != 0);
                r_ia = 5'($urandom);
            end
            if (!r_lr || e_ld_gnt || $urandom_range(9) == 0) begin
                r_lr = ($urandom_range(2) != 0);
                r_la = 5'($urandom);
            end
            cycle(r_ir, r_ia, r_lr, r_la);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fail);
        $finish;
    end
endmodule

// File: doc/rom_arbiter.md
Name: rom_arbiter

Overview:
- Shares the single read port of the instruction ROM between two requesters:
  - the IF stage (instruction fetch);
  - a load port (constant/literal reads from ROM by MEM stage or debug).
- Grants at most one request per cycle. Drives the ROM address. Registers ROM data back to the winner with 1-cycle latency.
- Fetch has default priority. A starvation counter forces a load grant after MAX_WAIT consecutive lost cycles.

Parameters:
ADDR_W, 5, ROM word-address width
INSTR_W, 32, ROM word width
MAX_WAIT, 4, consecutive denied cycles after which load port gets priority (1..15)

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
if_req  input  1  fetch request; held with if_addr stable until if_gnt
if_addr  input  ADDR_W  fetch word address
if_gnt  output  1  fetch granted this cycle (combinational)
if_rvalid  output  1  one-cycle pulse, if_rdata valid
if_rdata  output  INSTR_W  fetched word
ld_req  input  1  load request; held with ld_addr stable until ld_gnt
ld_addr  input  ADDR_W  load word address
ld_gnt  output  1  load granted this cycle (combinational)
ld_rvalid  output  1  one-cycle pulse, ld_rdata valid
ld_rdata  output  INSTR_W  loaded word
rom_addr  output  ADDR_W  address to ROM
rom_q  input  INSTR_W  ROM combinational read data for rom_addr

Behaviour:
- Reset (rst_n=0, async): if_rvalid=0, ld_rvalid=0, if_rdata=0, ld_rdata=0, wait_cnt=0, last_addr=0, owner=NONE. Outputs forced immediately, not at next edge.
- Grant logic (combinational, same cycle as req):
  - only if_req: if_gnt=1.
  - only ld_req: ld_gnt=1.
  - both, wait_cnt<MAX_WAIT: if_gnt=1.
  - both, wait_cnt==MAX_WAIT: ld_gnt=1.
  - if_gnt and ld_gnt never both 1.
- rom_addr: granted requester's address; with no grant, last_addr (last granted address, registered). ROM address is stable when idle.
- wait_cnt (saturating at MAX_WAIT), updated on clock edge:
  - ld_req=1 and ld_gnt=0: increments.
  - ld_gnt=1 or ld_req=0: clears to 0.
- Data return, registered at the edge ending the grant cycle: owner = IF, LD or NONE; rom_q captured into owner's rdata.
  - Next cycle: owner's rvalid=1 for exactly one cycle, other rvalid=0.
  - Non-owner's rdata holds its previous value.
- Throughput: back-to-back grants, one per cycle. A requester may keep req high across consecutive grants with new addresses each cycle. Each grant yields exactly one rvalid.
- Requester dropping req before gnt: permitted, no effect beyond wait_cnt clear.
- Reset mid-transaction: pending rvalid is cancelled, no data is returned. Requesters must re-issue.
- Latency: grant cycle N -> rvalid cycle N+1. Unloaded request sees gnt in cycle 0.
- MAX_WAIT bound: load worst-case wait = MAX_WAIT cycles. Fetch is delayed at most 1 cycle per forced load grant.

Test Plan:
- Reset: hold rst_n=0 with both req=1 -> all rvalid=0, rdata=0, rom_addr=0. Release; if_req=1, if_addr=3, ROM[3]=0x00500093 -> if_gnt same cycle; next cycle if_rvalid=1, if_rdata=0x00500093.
- Fetch stream: if_req=1 with addrs 0,1,2,3 on consecutive cycles -> if_gnt=1 every cycle; if_rvalid=1 for 4 consecutive cycles, data ROM[0..3] in order.
- Contention, MAX_WAIT=4: both req continuously, ld_addr=7 ->
  - if_gnt cycles 0-3;
  - ld_gnt cycle 4 with rom_addr=7;
  - ld_rvalid cycle 5 with ROM[7];
  - wait_cnt back to 0, fetch resumes cycle 5.
- Load alone: ld_req=1, ld_addr=31 -> ld_gnt immediately; ld_rvalid next cycle with ROM[31]; if_rvalid stays 0, if_rdata unchanged.
- Idle hold: after grant to addr 9, both req=0 for 3 cycles -> rom_addr stays 9, no rvalid pulses.
- Async reset mid-op: assert rst_n=0 between grant edge and next edge -> ld_rvalid/if_rvalid drop to 0 immediately, no pulse after release.
